// File: rtl/ascii_load_fifo.sv
// Byte FIFO between the file-download port and a CPU-visible RX data/status register pair.
// Optional ASCII_LOAD_LF2CR_EN: store LF as CR and drop the LF of a CRLF pair.
module ascii_load_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_W     = 14
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    input  logic              cs,
    input  logic              address,
    output logic [7:0]        dout,
    output logic              data_ready,
    output logic              overrun
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ALMOST = FULL - 1'b1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wptr_eff, rptr_eff;
    logic [DEPTH_LOG2:0]   count, cnt_eff;
    logic                  dl_q, cs_q;
    logic                  dl_rise, rd_edge, push_req, skip, full;
    logic                  pop, accept, drop, status_rd;
    logic [7:0]            wdata, head;

`ifdef ASCII_LOAD_LF2CR_EN
    logic last_cr;
`endif

    always_comb begin
        dl_rise   = ioctl_download & ~dl_q;
        rd_edge   = cs & ~cs_q;
        push_req  = ioctl_download & ioctl_wr;
        // A download rising edge flushes, so this cycle acts on an empty FIFO.
        cnt_eff   = dl_rise ? '0 : count;
        wptr_eff  = dl_rise ? '0 : wr_ptr;
        rptr_eff  = dl_rise ? '0 : rd_ptr;
`ifdef ASCII_LOAD_LF2CR_EN
        skip      = push_req & (ioctl_data == 8'h0A) & last_cr & ~dl_rise;
        wdata     = (ioctl_data == 8'h0A) ? 8'h0D : ioctl_data;
`else
        skip      = 1'b0;
        wdata     = ioctl_data;
`endif
        full      = (cnt_eff == FULL);
        pop       = rd_edge & ~address & (cnt_eff != '0);
        accept    = push_req & ~skip & (~full | pop);
        drop      = push_req & ~skip & full & ~pop;
        status_rd = rd_edge & address;
        head      = mem[rptr_eff];
    end

    assign data_ready = (count != '0);
    assign ioctl_wait = (count >= ALMOST);

    always_ff @(posedge clk25) begin
        if (accept) mem[wptr_eff] <= wdata;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            dl_q    <= 1'b0;
            cs_q    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            dout    <= 8'h00;
        end else begin
            dl_q    <= ioctl_download;
            cs_q    <= cs;
            wr_ptr  <= accept ? wptr_eff + 1'b1 : wptr_eff;
            rd_ptr  <= pop ? rptr_eff + 1'b1 : rptr_eff;
            count   <= cnt_eff + {{DEPTH_LOG2{1'b0}}, accept} - {{DEPTH_LOG2{1'b0}}, pop};
            // A drop in the same cycle as a status read survives into the next read.
            overrun <= drop | (overrun & ~status_rd & ~dl_rise);
            if (rd_edge) begin
                if (address)  dout <= {data_ready, overrun, 6'b0};
                else if (pop) dout <= {1'b1, head[6:0]};
                else          dout <= 8'h00;
            end
        end
    end

`ifdef ASCII_LOAD_LF2CR_EN
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst)           last_cr <= 1'b0;
        else if (push_req) last_cr <= (ioctl_data == 8'h0D);
        else if (dl_rise)  last_cr <= 1'b0;
    end
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, ioctl_addr, head[7]};
endmodule

// File: tb/tb_ascii_load_fifo.sv
// Directed plus randomized bench for ascii_load_fifo against a queue-based reference model.
module tb_ascii_load_fifo;
    localparam int DEPTH = 16;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [13:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        cs = 1'b0;
    logic        address = 1'b0;
    logic        ioctl_wait, data_ready, overrun;
    logic [7:0]  dout;

    int tests = 0;
    int fails = 0;

    byte unsigned q[$];
    bit m_ovr = 1'b0;
    bit m_cr  = 1'b0;

    ascii_load_fifo #(.DEPTH_LOG2(4), .ADDR_W(14)) dut (
        .clk25(clk25), .rst(rst), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
        .cs(cs), .address(address), .dout(dout), .data_ready(data_ready), .overrun(overrun)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_flush();
        q.delete();
        m_ovr = 1'b0;
        m_cr  = 1'b0;
    endfunction

    function automatic void m_push(input byte unsigned b);
        byte unsigned s;
        s = b;
`ifdef ASCII_LOAD_LF2CR_EN
        if (b == 8'h0A && m_cr) begin
            m_cr = 1'b0;
            return;
        end
        m_cr = (b == 8'h0D);
        if (b == 8'h0A) s = 8'h0D;
`endif
        if (q.size() < DEPTH) q.push_back(s);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [7:0] m_read(input bit stat);
        byte unsigned b;
        logic [7:0] r;
        if (stat) begin
            r = {q.size() != 0, m_ovr, 6'b0};
            m_ovr = 1'b0;
        end else if (q.size() == 0) begin
            r = 8'h00;
        end else begin
            b = q.pop_front();
            r = {1'b1, b[6:0]};
        end
        return r;
    endfunction

    task automatic chk_flags(input string tag);
        chk({tag, "/rdy"}, {7'b0, data_ready}, {7'b0, q.size() != 0});
        chk({tag, "/wait"}, {7'b0, ioctl_wait}, {7'b0, q.size() >= DEPTH - 1});
        chk({tag, "/ovr"}, {7'b0, overrun}, {7'b0, m_ovr});
    endtask

    task automatic push(input byte unsigned b);
        @(negedge clk25);
        ioctl_wr = 1'b1;
        ioctl_data = b;
        m_push(b);
        @(negedge clk25);
        ioctl_wr = 1'b0;
    endtask

    task automatic rd(input bit a, input string tag);
        logic [7:0] exp;
        exp = m_read(a);
        @(negedge clk25);
        cs = 1'b1;
        address = a;
        @(negedge clk25);
        cs = 1'b0;
        chk(tag, dout, exp);
        chk_flags(tag);
    endtask

    task automatic pushpop(input byte unsigned b, input string tag);
        logic [7:0] exp;
        exp = m_read(1'b0);
        m_push(b);
        @(negedge clk25);
        cs = 1'b1;
        address = 1'b0;
        ioctl_wr = 1'b1;
        ioctl_data = b;
        @(negedge clk25);
        cs = 1'b0;
        ioctl_wr = 1'b0;
        chk(tag, dout, exp);
        chk_flags(tag);
    endtask

    initial begin
        logic [7:0] exp;
        byte unsigned b;
        int r;

        // Reset state
        #1;
        chk("rst/dout", dout, 8'h00);
        chk_flags("rst");
        @(negedge clk25);
        rst = 1'b0;

        // Start a download, push two bytes and read them back
        @(negedge clk25);
        ioctl_download = 1'b1;
        m_flush();
        push(8'h41);
        push(8'h42);
        rd(1'b0, "rd_a");
        chk("rd_a/const", dout, 8'hC1);
        chk("rd_a/rdy1", {7'b0, data_ready}, 8'h01);
        rd(1'b0, "rd_b");
        chk("rd_b/const", dout, 8'hC2);
        chk("rd_b/rdy0", {7'b0, data_ready}, 8'h00);

        // Fill to 15 (wait asserts), then full, then drop
        for (int i = 0; i < 14; i++) push(8'h20 + i);
        chk_flags("fill14");
        push(8'h30);
        chk("fill15/wait", {7'b0, ioctl_wait}, 8'h01);
        push(8'h31);
        push(8'h32);
        chk_flags("fill17");
        rd(1'b1, "stat_full");
        chk("stat_full/const", dout, 8'hC0);
        chk("stat_full/ovr_clr", {7'b0, overrun}, 8'h00);
        pushpop(8'h77, "full_pushpop");
        for (int i = 0; i < DEPTH; i++) rd(1'b0, "drain");
        rd(1'b0, "drain_empty");

        // Held chip select gives exactly one pop
        push(8'h61);
        push(8'h62);
        push(8'h63);
        exp = m_read(1'b0);
        @(negedge clk25);
        cs = 1'b1;
        address = 1'b0;
        repeat (5) @(negedge clk25);
        cs = 1'b0;
        chk("held_cs/dout", dout, exp);
        chk("held_cs/qsize", 8'(q.size()), 8'd2);
        rd(1'b0, "held_cs_r2");
        rd(1'b0, "held_cs_r3");
        rd(1'b0, "held_cs_empty");
        chk("empty/const", dout, 8'h00);

        // Push and pop together at count 1
        push(8'h5A);
        pushpop(8'h5B, "pp1");
        rd(1'b0, "pp1_next");
        rd(1'b0, "pp1_empty");

        // CR/LF handling
        push(8'h0D);
        push(8'h0A);
        push(8'h0A);
        rd(1'b0, "crlf1");
        chk("crlf1/const", dout, 8'h8D);
        rd(1'b0, "crlf2");
`ifdef ASCII_LOAD_LF2CR_EN
        chk("crlf2/const", dout, 8'h8D);
        rd(1'b0, "crlf3");
        chk("crlf3/const", dout, 8'h00);
`else
        chk("crlf2/const", dout, 8'h8A);
        rd(1'b0, "crlf3");
        chk("crlf3/const", dout, 8'h8A);
`endif
        while (q.size() != 0) rd(1'b0, "crlf_drain");

        // Overflow, end download (no flush), then restart with a push in the rising cycle
        for (int i = 0; i < DEPTH + 1; i++) push(8'h40 + i);
        @(negedge clk25);
        ioctl_download = 1'b0;
        @(negedge clk25);
        chk_flags("dl_fall");
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_data = 8'h55;
        m_flush();
        m_push(8'h55);
        @(negedge clk25);
        ioctl_wr = 1'b0;
        chk_flags("dl_rise");
        rd(1'b0, "dl_rise_first");
        chk("dl_rise_first/const", dout, 8'hD5);
        rd(1'b0, "dl_rise_empty");

        // Reset mid-download, push accepted in the release cycle
        push(8'h11);
        push(8'h12);
        push(8'h13);
        #7 rst = 1'b1;
        #1;
        chk("async_rst/rdy", {7'b0, data_ready}, 8'h00);
        chk("async_rst/dout", dout, 8'h00);
        @(negedge clk25);
        rst = 1'b0;
        ioctl_wr = 1'b1;
        ioctl_data = 8'h3C;
        m_flush();
        m_push(8'h3C);
        @(negedge clk25);
        ioctl_wr = 1'b0;
        rd(1'b0, "rst_rel_push");
        rd(1'b0, "rst_rel_empty");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A)
                                            : 8'($urandom_range(0, 255));
            if (r <= 4)      push(b);
            else if (r <= 6) rd(1'b0, "rand_data");
            else if (r == 7) rd(1'b1, "rand_stat");
            else if (r == 8) pushpop(b, "rand_pp");
            else begin
                @(negedge clk25);
                chk_flags("rand_idle");
            end
        end
        while (q.size() != 0) rd(1'b0, "rand_drain");
        rd(1'b0, "rand_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ascii_load_fifo.md
ASCII_LOAD_FIFO -- requirements
Module: ascii_load_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning width of ioctl_addr.
REQ-003 SHALL have port clk25  in  1  25 MHz system clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ioctl_download  in  1  file download in progress.
REQ-006 SHALL have port ioctl_wr  in  1  one-cycle strobe, ioctl_data valid.
REQ-007 SHALL have port ioctl_addr  in  ADDR_W  byte offset in file, unused except for its width.
REQ-008 SHALL have port ioctl_data  in  8  file byte.
REQ-009 SHALL have port ioctl_wait  out  1  back-pressure to loader.
REQ-010 SHALL have port cs  in  1  CPU chip select, level, may be held several cycles.
REQ-011 SHALL have port address  in  1  0 = RX data, 1 = RX status.
REQ-012 SHALL have port dout  out  8  registered CPU read data.
REQ-013 SHALL have port data_ready  out  1  FIFO non-empty.
REQ-014 SHALL have port overrun  out  1  sticky: a byte was dropped.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH bytes with write pointer, read pointer and a count of DEPTH_LOG2+1 bits; pointers wrap modulo DEPTH.
REQ-016 Push: ioctl_download & ioctl_wr & count<DEPTH -> byte stored at write pointer, pointer+1, count+1, same cycle.
REQ-017 Push when count==DEPTH SHALL drop the byte, leave pointers unchanged, set overrun.
REQ-018 ioctl_wait SHALL be combinational (count >= DEPTH-1), giving the loader one strobe of margin.
REQ-019 CPU read edge SHALL be cs rising (cs & !cs_q, cs_q registered); held cs SHALL cause exactly one access.
REQ-020 Data read (address=0) on read edge: non-empty -> dout <= {1, head[6:0]}, pop (rd ptr+1, count-1); empty -> dout <= 8'h00, no pop.
REQ-021 Status read (address=1) on read edge SHALL set dout <= {data_ready, overrun, 6'b0} and SHALL clear overrun.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; at count==DEPTH a same-cycle pop SHALL allow the push.
REQ-023 data_ready SHALL be (count != 0), combinational from count.
REQ-024 A rising edge of ioctl_download SHALL flush FIFO (pointers and count to 0) and clear overrun; a push in that same cycle SHALL be stored as the first entry.
REQ-025 Falling ioctl_download SHALL NOT flush; remaining bytes stay readable.
REQ-026 dout SHALL hold its value between read edges.

Reset
REQ-027 rst SHALL asynchronously clear pointers, count, overrun, cs_q, download-edge register, dout to 8'h00.
REQ-028 After reset: data_ready=0, ioctl_wait=0, overrun=0; FIFO storage contents need not be reset.
REQ-029 rst asserted mid-download SHALL discard all buffered bytes; the push in the release cycle SHALL be accepted normally.

Configuration
REQ-030 Macro ASCII_LOAD_LF2CR_EN defined: pushed byte 8'h0A SHALL be stored as 8'h0D, and an 8'h0A immediately following a pushed 8'h0D (CRLF) SHALL be discarded without setting overrun.
REQ-031 Macro undefined: bytes SHALL be stored verbatim; no CRLF state register synthesized.

Verification
REQ-032 Reset, push 8'h41,8'h42, two data reads -> dout 8'hC1 then 8'hC2; data_ready 1 then 0.
REQ-033 DEPTH=16: push 16 bytes -> ioctl_wait=1 at count 15; 17th push dropped; status read -> dout 8'hC0, overrun cleared afterwards.
REQ-034 Hold cs=1,address=0 for 5 cycles with 3 bytes queued -> one pop only, count 2.
REQ-035 Data read on empty FIFO -> dout 8'h00, count stays 0; push and pop in the same cycle at count 1 -> count stays 1.
REQ-036 With ASCII_LOAD_LF2CR_EN: push 8'h0D,8'h0A,8'h0A -> reads 8'h8D, 8'h8D, then empty; without macro -> 8'h8D, 8'h8A, 8'h8A.
REQ-037 Second ioctl_download rising with 4 bytes queued -> count 0, overrun 0, first new byte read next.
